// File: rtl/vc_input_unit.sv
// vc_input_unit: router input port with NUM_VC virtual channels.
// Each VC owns a flit FIFO and a packet state machine. Head flits are
// XY-routed, the VC then requests the switch allocator, and each granted
// flit is forwarded one cycle later together with a credit for its VC.
//
// State table (per VC):
//   state      | meaning
//   VC_IDLE    | no packet open; waits for a head at the FIFO front
//   VC_ROUTING | one cycle: XY route of the front head is computed and latched
//   VC_ACTIVE  | packet open; requests the switch while the FIFO holds flits
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_flit_valid/flit incoming flit {type[1:0], vc id, payload}
//   o_credit_valid/vc one credit per dequeued flit, registered
//   o_sw_req          per-VC switch request
//   o_sw_port         per-VC latched one-hot port {L,W,S,E,N}, 5 bits per VC
//   i_sw_grant        one-hot grant, same cycle as the request
//   o_flit_valid/flit forwarded flit, registered
//   o_vc_busy         VC not idle
//   o_err             sticky protocol error
module vc_input_unit #(
  parameter int NUM_VC    = 4,
  parameter int BUF_DEPTH = 8,
  parameter int FLIT_W    = 34,
  parameter int CW        = 4,
  parameter int X_COORD   = 0,
  parameter int Y_COORD   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flit_valid,
  input  logic [FLIT_W-1:0]         i_flit,
  output logic                      o_credit_valid,
  output logic [$clog2(NUM_VC)-1:0] o_credit_vc,
  output logic [NUM_VC-1:0]         o_sw_req,
  output logic [5*NUM_VC-1:0]       o_sw_port,
  input  logic [NUM_VC-1:0]         i_sw_grant,
  output logic                      o_flit_valid,
  output logic [FLIT_W-1:0]         o_flit,
  output logic [NUM_VC-1:0]         o_vc_busy,
  output logic                      o_err
);

  localparam int VCW     = $clog2(NUM_VC);
  localparam int AW      = $clog2(BUF_DEPTH);
  localparam int CNTW    = AW + 1;
  localparam int TYPE_HI = FLIT_W - 1;
  localparam int VC_HI   = FLIT_W - 3;
  localparam int VC_LO   = FLIT_W - 2 - VCW;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(BUF_DEPTH);
  localparam logic [CW-1:0]   MY_X     = CW'(X_COORD);
  localparam logic [CW-1:0]   MY_Y     = CW'(Y_COORD);

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_ROUTING = 2'd1,
    VC_ACTIVE  = 2'd2
  } vc_state_e;

  logic [FLIT_W-1:0] mem [NUM_VC][BUF_DEPTH];
  logic [AW-1:0]     rd_ptr [NUM_VC];
  logic [AW-1:0]     wr_ptr [NUM_VC];
  logic [CNTW-1:0]   count  [NUM_VC];
  vc_state_e         state_q   [NUM_VC];
  vc_state_e         state_nxt [NUM_VC];
  logic [4:0]        port_q    [NUM_VC];
  logic [4:0]        port_nxt  [NUM_VC];
  logic [FLIT_W-1:0] front     [NUM_VC];

  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] wr_hit;
  logic [NUM_VC-1:0] deq_hit;
  logic [VCW-1:0]    wr_vc;
  logic              wr_ok;
  logic              drop;
  logic              grant_multi;
  logic              pop_en;
  logic [VCW-1:0]    pop_vc;
  logic              disc_any;
  logic [VCW-1:0]    disc_vc;
  logic              deq_en;
  logic [VCW-1:0]    deq_vc;
  logic [FLIT_W-1:0] pop_flit;

  // Port encoding {L,W,S,E,N}: X is resolved before Y.
  function automatic logic [4:0] xy_route(input logic [CW-1:0] dx,
                                          input logic [CW-1:0] dy);
    logic [4:0] p;
    if (dx > MY_X)      p = 5'b00010;
    else if (dx < MY_X) p = 5'b01000;
    else if (dy > MY_Y) p = 5'b00001;
    else if (dy < MY_Y) p = 5'b00100;
    else                p = 5'b10000;
    return p;
  endfunction

  assign wr_vc = i_flit[VC_HI:VC_LO];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      front[v]              = mem[v][rd_ptr[v]];
      req[v]                = (state_q[v] == VC_ACTIVE) && (count[v] != '0);
      o_sw_req[v]           = req[v];
      o_sw_port[5*v +: 5]   = port_q[v];
      o_vc_busy[v]          = (state_q[v] != VC_IDLE);
    end
  end

  // Grant legality is judged on the raw grant vector; a multi-bit grant
  // blocks the pop even if only one of the granted VCs is requesting.
  always_comb begin
    grant_multi = (i_sw_grant & (i_sw_grant - NUM_VC'(1))) != '0;
    pop_en   = 1'b0;
    pop_vc   = '0;
    disc_any = 1'b0;
    disc_vc  = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (!grant_multi && i_sw_grant[v] && req[v]) begin
        pop_en = 1'b1;
        pop_vc = VCW'(v);
      end
      // Stray BODY/TAIL at the front of an idle VC; lowest VC wins.
      if (state_q[v] == VC_IDLE && count[v] != '0 && !front[v][TYPE_HI-1]) begin
        disc_any = 1'b1;
        disc_vc  = VCW'(v);
      end
    end
    pop_flit = front[pop_vc];
    deq_en   = pop_en || disc_any;
    deq_vc   = pop_en ? pop_vc : disc_vc;
    // A full FIFO still accepts a write when the same VC dequeues this cycle.
    wr_ok    = i_flit_valid &&
               ((count[wr_vc] != FULL_CNT) || (deq_en && deq_vc == wr_vc));
    drop     = i_flit_valid && !wr_ok;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v]  = wr_ok && (wr_vc == VCW'(v));
      deq_hit[v] = deq_en && (deq_vc == VCW'(v));
    end
  end

  // An empty idle VC looks at the incoming flit so a head starts routing
  // on the same edge that writes it.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_nxt[v] = state_q[v];
      port_nxt[v]  = port_q[v];
      case (state_q[v])
        VC_IDLE: begin
          if (count[v] != '0) begin
            if (front[v][TYPE_HI-1]) state_nxt[v] = VC_ROUTING;
          end else if (wr_hit[v] && i_flit[TYPE_HI-1]) begin
            state_nxt[v] = VC_ROUTING;
          end
        end
        VC_ROUTING: begin
          port_nxt[v]  = xy_route(front[v][2*CW-1:CW], front[v][CW-1:0]);
          state_nxt[v] = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (pop_en && pop_vc == VCW'(v) && front[v][TYPE_HI]) begin
            state_nxt[v] = VC_IDLE;
            port_nxt[v]  = 5'b00000;
          end
        end
        default: begin
          state_nxt[v] = VC_IDLE;
          port_nxt[v]  = 5'b00000;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_vc][wr_ptr[wr_vc]] <= i_flit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= VC_IDLE;
        port_q[v]  <= 5'b00000;
        count[v]   <= '0;
        rd_ptr[v]  <= '0;
        wr_ptr[v]  <= '0;
      end
      o_flit_valid   <= 1'b0;
      o_flit         <= '0;
      o_credit_valid <= 1'b0;
      o_credit_vc    <= '0;
      o_err          <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= state_nxt[v];
        port_q[v]  <= port_nxt[v];
        if (wr_hit[v])  wr_ptr[v] <= wr_ptr[v] + AW'(1);
        if (deq_hit[v]) rd_ptr[v] <= rd_ptr[v] + AW'(1);
        if (wr_hit[v] && !deq_hit[v])      count[v] <= count[v] + CNTW'(1);
        else if (!wr_hit[v] && deq_hit[v]) count[v] <= count[v] - CNTW'(1);
      end
      o_flit_valid   <= pop_en;
      o_flit         <= pop_en ? pop_flit : '0;
      o_credit_valid <= deq_en;
      o_credit_vc    <= deq_en ? deq_vc : '0;
      if (drop || grant_multi || disc_any) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_unit.sv
// Scoreboard bench for vc_input_unit (router at X=1, Y=1).
module tb_vc_input_unit;
  localparam int NUM_VC = 4;
  localparam int FLIT_W = 34;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic              clk;
  logic              reset;
  logic              i_flit_valid;
  logic [FLIT_W-1:0] i_flit;
  logic              o_credit_valid;
  logic [1:0]        o_credit_vc;
  logic [3:0]        o_sw_req;
  logic [19:0]       o_sw_port;
  logic [3:0]        i_sw_grant;
  logic              o_flit_valid;
  logic [FLIT_W-1:0] o_flit;
  logic [3:0]        o_vc_busy;
  logic              o_err;

  vc_input_unit #(.NUM_VC(4), .BUF_DEPTH(8), .FLIT_W(34), .CW(4),
                  .X_COORD(1), .Y_COORD(1)) dut (
    .clk(clk), .reset(reset), .i_flit_valid(i_flit_valid), .i_flit(i_flit),
    .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc),
    .o_sw_req(o_sw_req), .o_sw_port(o_sw_port), .i_sw_grant(i_sw_grant),
    .o_flit_valid(o_flit_valid), .o_flit(o_flit), .o_vc_busy(o_vc_busy),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FLIT_W-1:0] exp_flit_q [$];
  logic [1:0]        exp_cred_q [$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [1:0] vc,
                                           input logic [21:0] tag, input logic [3:0] dx,
                                           input logic [3:0] dy);
    return {t, vc, tag, dx, dy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the negedge; the step ends at the next negedge.
  task automatic step(input logic v, input logic [FLIT_W-1:0] f,
                      input logic [3:0] g, input bit auto_g);
    i_flit_valid = v;
    i_flit       = f;
    if (auto_g) i_sw_grant = o_sw_req & (~o_sw_req + 4'd1);
    else        i_sw_grant = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 4'b0000, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send(input logic [FLIT_W-1:0] f);
    exp_flit_q.push_back(f);
    exp_cred_q.push_back(f[31:30]);
  endtask

  // Monitor: every forwarded flit and credit is matched against the queues.
  always @(negedge clk) begin
    logic [FLIT_W-1:0] ef;
    logic [1:0]        ec;
    if (o_flit_valid === 1'b1) begin
      n_vec++;
      if (exp_flit_q.size() == 0) begin
        n_err++;
        $display("FAIL flit_unexpected: got %h, expected none", o_flit);
      end else begin
        ef = exp_flit_q.pop_front();
        if (o_flit !== ef) begin
          n_err++;
          $display("FAIL flit_data: got %h, expected %h", o_flit, ef);
        end
      end
    end
    if (o_credit_valid === 1'b1) begin
      n_vec++;
      if (exp_cred_q.size() == 0) begin
        n_err++;
        $display("FAIL credit_unexpected: got vc %0d, expected none", o_credit_vc);
      end else begin
        ec = exp_cred_q.pop_front();
        if (o_credit_vc !== ec) begin
          n_err++;
          $display("FAIL credit_vc: got %0d, expected %0d", o_credit_vc, ec);
        end
      end
    end
  end

  logic [3:0] rdx   [5] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd1};
  logic [3:0] rdy   [5] = '{4'd1, 4'd0, 4'd3, 4'd2, 4'd0};
  logic [4:0] rport [5] = '{5'b10000, 5'b00010, 5'b01000, 5'b00001, 5'b00100};

  initial begin
    logic [FLIT_W-1:0] f;
    logic [1:0] ty;
    reset = 1'b1; i_flit_valid = 1'b0; i_flit = '0; i_sw_grant = '0;
    @(negedge clk);
    do_reset();
    chk("rst_credit_valid", o_credit_valid, 0);
    chk("rst_credit_vc", o_credit_vc, 0);
    chk("rst_sw_req", o_sw_req, 0);
    chk("rst_sw_port", o_sw_port, 0);
    chk("rst_flit_valid", o_flit_valid, 0);
    chk("rst_flit", o_flit, 0);
    chk("rst_vc_busy", o_vc_busy, 0);
    chk("rst_err", o_err, 0);

    // Head/body/tail on VC0 to (3,1): East, 3 back-to-back flits.
    send(mk(T_HEAD, 2'd0, 22'h11, 4'd3, 4'd1));
    send(mk(T_BODY, 2'd0, 22'h12, 4'd0, 4'd0));
    send(mk(T_TAIL, 2'd0, 22'h13, 4'd0, 4'd0));
    step(1'b1, mk(T_HEAD, 2'd0, 22'h11, 4'd3, 4'd1), 4'b0, 1'b1);
    chk("p1_busy_routing", o_vc_busy[0], 1);
    chk("p1_req_routing", o_sw_req[0], 0);
    step(1'b1, mk(T_BODY, 2'd0, 22'h12, 4'd0, 4'd0), 4'b0, 1'b1);
    chk("p1_port_e", o_sw_port[4:0], 5'b00010);
    chk("p1_req_active", o_sw_req[0], 1);
    step(1'b1, mk(T_TAIL, 2'd0, 22'h13, 4'd0, 4'd0), 4'b0, 1'b1);
    chk("p1_fv_edge3", o_flit_valid, 1);
    step(1'b0, '0, 4'b0, 1'b1);
    chk("p1_fv_edge4", o_flit_valid, 1);
    step(1'b0, '0, 4'b0, 1'b1);
    chk("p1_fv_edge5", o_flit_valid, 1);
    chk("p1_idle", o_vc_busy[0], 0);
    chk("p1_port_clr", o_sw_port[4:0], 0);
    step(1'b0, '0, 4'b0, 1'b1);
    chk("p1_fv_done", o_flit_valid, 0);

    // HEADTAIL on VC2 through every XY route outcome.
    for (int i = 0; i < 5; i++) begin
      f = mk(T_HT, 2'd2, 22'h20 + 22'(i), rdx[i], rdy[i]);
      send(f);
      step(1'b1, f, 4'b0, 1'b1);
      chk("ht_busy1", o_vc_busy[2], 1);
      step(1'b0, '0, 4'b0, 1'b1);
      chk("ht_port", o_sw_port[14:10], rport[i]);
      chk("ht_busy2", o_vc_busy[2], 1);
      step(1'b0, '0, 4'b0, 1'b1);
      chk("ht_busy3", o_vc_busy[2], 0);
      chk("ht_fv", o_flit_valid, 1);
    end
    chk("ht_no_err", o_err, 0);

    // Stray BODY on idle VC2: discarded with a credit and an error.
    do_reset();
    exp_cred_q.push_back(2'd2);
    step(1'b1, mk(T_BODY, 2'd2, 22'h2f, 4'd0, 4'd0), 4'b0, 1'b0);
    step(1'b0, '0, 4'b0, 1'b0);
    chk("disc_credit", o_credit_valid, 1);
    chk("disc_err", o_err, 1);
    chk("disc_fv", o_flit_valid, 0);
    chk("disc_busy", o_vc_busy, 0);

    // VC1 overflow: 9th write dropped, then 8 granted pops in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ty = (i == 0) ? T_HEAD : ((i == 7) ? T_TAIL : T_BODY);
      f = mk(ty, 2'd1, 22'h100 + 22'(i), 4'd1, 4'd1);
      send(f);
      step(1'b1, f, 4'b0, 1'b0);
    end
    chk("ovf_err_before", o_err, 0);
    step(1'b1, mk(T_BODY, 2'd1, 22'h1ff, 4'd0, 4'd0), 4'b0, 1'b0);
    chk("ovf_err_after", o_err, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 4'b0010, 1'b0);
    chk("ovf_idle", o_vc_busy[1], 0);
    step(1'b0, '0, 4'b0010, 1'b0);
    chk("ovf_no_9th", o_flit_valid, 0);

    // VC0 full, simultaneous write and pop: nothing dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      f = mk((i == 0) ? T_HEAD : T_BODY, 2'd0, 22'h200 + 22'(i), 4'd1, 4'd0);
      send(f);
      step(1'b1, f, 4'b0, 1'b0);
    end
    f = mk(T_TAIL, 2'd0, 22'h208, 4'd0, 4'd0);
    send(f);
    step(1'b1, f, 4'b0001, 1'b0);
    chk("full_rw_err", o_err, 0);
    chk("full_rw_fv", o_flit_valid, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 4'b0, 1'b1);
    chk("full_rw_idle", o_vc_busy[0], 0);
    chk("full_rw_err_end", o_err, 0);

    // Interleaved VC0/VC3 packets; a two-bit grant pops nothing.
    do_reset();
    step(1'b1, mk(T_HEAD, 2'd0, 22'h300, 4'd1, 4'd2), 4'b0, 1'b0);
    step(1'b1, mk(T_HEAD, 2'd3, 22'h330, 4'd0, 4'd1), 4'b0, 1'b0);
    step(1'b1, mk(T_BODY, 2'd0, 22'h301, 4'd0, 4'd0), 4'b0, 1'b0);
    step(1'b1, mk(T_BODY, 2'd3, 22'h331, 4'd0, 4'd0), 4'b0, 1'b0);
    step(1'b1, mk(T_TAIL, 2'd0, 22'h302, 4'd0, 4'd0), 4'b0, 1'b0);
    step(1'b1, mk(T_TAIL, 2'd3, 22'h332, 4'd0, 4'd0), 4'b0, 1'b0);
    chk("il_req", o_sw_req, 4'b1001);
    chk("il_ports", {o_sw_port[19:15], o_sw_port[4:0]}, {5'b01000, 5'b00001});
    step(1'b0, '0, 4'b0011, 1'b0);
    chk("il_multi_err", o_err, 1);
    chk("il_multi_nopop", o_flit_valid, 0);
    send(mk(T_HEAD, 2'd0, 22'h300, 4'd1, 4'd2));
    send(mk(T_HEAD, 2'd3, 22'h330, 4'd0, 4'd1));
    send(mk(T_BODY, 2'd0, 22'h301, 4'd0, 4'd0));
    send(mk(T_BODY, 2'd3, 22'h331, 4'd0, 4'd0));
    send(mk(T_TAIL, 2'd0, 22'h302, 4'd0, 4'd0));
    send(mk(T_TAIL, 2'd3, 22'h332, 4'd0, 4'd0));
    for (int i = 0; i < 6; i++) step(1'b0, '0, (i % 2 == 0) ? 4'b0001 : 4'b1000, 1'b0);
    chk("il_busy_end", o_vc_busy, 0);

    // Reset in the middle of a VC1 packet flushes it silently.
    do_reset();
    step(1'b1, mk(T_HEAD, 2'd1, 22'h400, 4'd2, 4'd2), 4'b0, 1'b0);
    step(1'b1, mk(T_BODY, 2'd1, 22'h401, 4'd0, 4'd0), 4'b0, 1'b0);
    step(1'b1, mk(T_BODY, 2'd1, 22'h402, 4'd0, 4'd0), 4'b0, 1'b0);
    chk("mid_req", o_sw_req[1], 1);
    reset = 1'b1;
    step(1'b1, mk(T_BODY, 2'd1, 22'h403, 4'd0, 4'd0), 4'b0010, 1'b0);
    reset = 1'b0;
    chk("mid_credit_valid", o_credit_valid, 0);
    chk("mid_flit_valid", o_flit_valid, 0);
    chk("mid_flit", o_flit, 0);
    chk("mid_sw_req", o_sw_req, 0);
    chk("mid_sw_port", o_sw_port, 0);
    chk("mid_busy", o_vc_busy, 0);
    chk("mid_err", o_err, 0);
    step(1'b0, '0, 4'b0010, 1'b0);
    chk("mid_no_credit", o_credit_valid, 0);
    f = mk(T_HT, 2'd1, 22'h410, 4'd0, 4'd1);
    send(f);
    step(1'b1, f, 4'b0, 1'b1);
    step(1'b0, '0, 4'b0, 1'b1);
    chk("mid_new_port_w", o_sw_port[9:5], 5'b01000);
    step(1'b0, '0, 4'b0, 1'b1);
    chk("mid_new_fv", o_flit_valid, 1);
    step(1'b0, '0, 4'b0, 1'b1);
    step(1'b0, '0, 4'b0, 1'b1);

    chk("end_flits_left", exp_flit_q.size(), 0);
    chk("end_credits_left", exp_cred_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
